// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with first-word-valid read port
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with per-frame runtime configuration
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]        LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]        BIT_ONE   = BW'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  load;

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DIV_WIDTH-1:0]  div_lat;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en;
    logic                  par_bit;
    logic                  stop2_lat;
    logic                  stop_second;
    logic                  tx_r;

    logic [DIV_WIDTH-1:0]  eff_div;
    logic                  bit_done;
    logic                  stop_done;
    parity_e               cfg_par;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (s_valid),
        .wdata (s_data),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign cfg_par   = parity_e'(cfg_parity);
    assign eff_div   = (cfg_div < DIV_FLOOR) ? DIV_FLOOR : cfg_div;
    assign bit_done  = (div_cnt == '0);
    assign stop_done = (state == STOP) && bit_done && (!stop2_lat || stop_second);
    // A new frame starts from IDLE or straight out of the last stop cycle, so queued frames abut.
    assign load      = !fifo_empty && ((state == IDLE) || stop_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tx_r        <= 1'b1;
            shreg       <= '0;
            div_lat     <= DIV_FLOOR;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2_lat   <= 1'b0;
            stop_second <= 1'b0;
        end else if (load) begin
            state       <= START;
            tx_r        <= 1'b0;
            shreg       <= fifo_rdata;
            div_lat     <= eff_div;
            div_cnt     <= eff_div - DIV_ONE;
            bit_cnt     <= '0;
            par_en      <= (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
            par_bit     <= (^fifo_rdata) ^ (cfg_par == PAR_ODD);
            stop2_lat   <= cfg_stop2;
            stop_second <= 1'b0;
        end else if (state != IDLE && !bit_done) begin
            div_cnt <= div_cnt - DIV_ONE;
        end else begin
            case (state)
                START: begin
                    state   <= DATA;
                    div_cnt <= div_lat - DIV_ONE;
                    bit_cnt <= '0;
                    tx_r    <= shreg[0];
                end
                DATA: begin
                    div_cnt <= div_lat - DIV_ONE;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en) begin
                            state <= PARITY;
                            tx_r  <= par_bit;
                        end else begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end
                    end else begin
                        shreg   <= shreg >> 1;
                        tx_r    <= shreg[1];
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    tx_r    <= 1'b1;
                    div_cnt <= div_lat - DIV_ONE;
                end
                STOP: begin
                    if (stop2_lat && !stop_second) begin
                        stop_second <= 1'b1;
                        div_cnt     <= div_lat - DIV_ONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign s_ready = !fifo_full;
    assign busy    = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized bench for uart_tx_cfg with a line-level reference model
module tb_uart_tx_cfg;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic [DIVW-1:0] cfg_div = 16'd4;
    logic [1:0]      cfg_parity = 2'b00;
    logic            cfg_stop2 = 1'b0;
    logic            tx;
    logic            busy;
    logic [2:0]      fifo_level;

    int total = 0;
    int bad   = 0;

    uart_tx_cfg #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference: a queue of pending words and a queue of future line levels, one entry per clock.
    logic [DW-1:0] mq[$];
    bit            lq[$];
    bit            m_tx = 1'b1;
    bit            m_busy = 1'b0;
    int            m_level = 0;

    function automatic void add_frame(input logic [DW-1:0] w, input logic [DIVW-1:0] dv,
                                      input logic [1:0] par, input logic s2);
        int d;
        bit seq[$];
        d = (dv < 16'd2) ? 2 : int'(dv);
        seq.push_back(1'b0);
        for (int i = 0; i < DW; i++) seq.push_back(w[i]);
        if (par == 2'b01) seq.push_back(^w);
        else if (par == 2'b10) seq.push_back(~^w);
        seq.push_back(1'b1);
        if (s2) seq.push_back(1'b1);
        foreach (seq[i]) for (int j = 0; j < d; j++) lq.push_back(seq[i]);
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete();
                lq.delete();
                m_tx    = 1'b1;
                m_busy  = 1'b0;
                m_level = 0;
            end else begin
                int pre;
                bit in_frame;
                pre = mq.size();
                if (lq.size() == 0 && pre > 0) add_frame(mq.pop_front(), cfg_div, cfg_parity, cfg_stop2);
                if (lq.size() > 0) begin
                    m_tx     = lq.pop_front();
                    in_frame = 1'b1;
                end else begin
                    m_tx     = 1'b1;
                    in_frame = 1'b0;
                end
                if (s_valid && pre < DEPTH) mq.push_back(s_data);
                m_busy  = in_frame || (mq.size() > 0);
                m_level = mq.size();
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("tx", {31'd0, tx}, {31'd0, m_tx});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("fifo_level", {29'd0, fifo_level}, m_level);
            chk("s_ready", {31'd0, s_ready}, {31'd0, (m_level < DEPTH)});
        end
    end

    logic cap[$];
    logic bcap[$];

    task automatic capture(input int n);
        cap.delete();
        bcap.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap.push_back(tx);
            bcap.push_back(busy);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", {31'd0, (n < 500)}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || lq.size() != 0 || mq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, (n < 3000)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        logic [9:0] bits10;
        logic [4:0] bits5;
        int         ones;

        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, div 4, no parity, one stop bit
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push_word(8'hA5);
        capture(41);
        for (int i = 0; i < 10; i++) bits10[i] = cap[i*4 + 2];
        chk("a5_bits", {22'd0, bits10}, 32'h34A);
        chk("a5_start_len", {31'd0, cap[3] | cap[0]}, 32'd0);
        chk("a5_busy_last", {31'd0, bcap[39]}, 32'd1);
        chk("a5_busy_end", {31'd0, bcap[40]}, 32'd0);
        wait_idle();

        // 0x07, div 3, even then odd parity
        cfg_div = 16'd3; cfg_parity = 2'b01;
        push_word(8'h07);
        capture(34);
        chk("even_par", {31'd0, cap[28]}, 32'd1);
        chk("par_busy_last", {31'd0, bcap[32]}, 32'd1);
        chk("par_busy_end", {31'd0, bcap[33]}, 32'd0);
        wait_idle();
        cfg_parity = 2'b10;
        push_word(8'h07);
        capture(34);
        chk("odd_par", {31'd0, cap[28]}, 32'd0);
        wait_idle();

        // two stop bits at div 5
        cfg_div = 16'd5; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        push_word(8'h00);
        capture(56);
        ones = 0;
        for (int i = 45; i < 55; i++) ones += int'(cap[i]);
        chk("stop2_ones", ones, 32'd10);
        chk("stop2_pre", {31'd0, cap[44]}, 32'd0);
        chk("stop2_busy_last", {31'd0, bcap[54]}, 32'd1);
        chk("stop2_busy_end", {31'd0, bcap[55]}, 32'd0);
        wait_idle();

        // divisor 0 behaves as 2
        cfg_div = 16'd0; cfg_stop2 = 1'b0;
        push_word(8'h01);
        capture(21);
        for (int i = 0; i < 5; i++) bits5[i] = cap[i];
        chk("div0_bits", {27'd0, bits5}, 32'h0C);
        chk("div0_busy_end", {31'd0, bcap[20]}, 32'd0);
        wait_idle();

        // fill the FIFO while the line is busy
        cfg_div = 16'd2;
        for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i));
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ready", {31'd0, s_ready}, 32'd0);
        push_word(8'h99);
        wait_idle();

        // config change mid-frame applies only to the next frame
        cfg_div = 16'd4; cfg_parity = 2'b00;
        push_word(8'h3C);
        repeat (10) @(negedge clk);
        cfg_div = 16'd3; cfg_parity = 2'b01;
        push_word(8'h5A);
        wait_idle();

        // randomized traffic with occasional reconfiguration
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 3) == 0);
            s_data  = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                cfg_div    = 16'($urandom_range(0, 6));
                cfg_parity = 2'($urandom_range(0, 3));
                cfg_stop2  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        wait_idle();

        // reset during DATA
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        push_word(8'h55);
        push_word(8'hC3);
        push_word(8'h0F);
        repeat (12) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_tx", {31'd0, tx}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter. It replaces the fixed-rate, single-word transmitter. A small input FIFO decouples the producer from the line. Baud divisor, parity mode and stop-bit count are configured at runtime and latched per frame. Frames go out back-to-back with no idle gap while data is queued. The block sits between any valid/ready byte producer (CPU bridge, test pattern engine) and the serial TX pin.

## Interface
- DATA_WIDTH, 8: bits per character, 5..9.
- FIFO_DEPTH, 4: input buffer entries; power of 2, ≥2.
- DIV_WIDTH, 16: width of runtime baud divisor.
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  producer has a character.
- s_ready  out  1  FIFO can accept; equals !full.
- s_data  in  DATA_WIDTH  character, LSB sent first.
- cfg_div  in  DIV_WIDTH  clocks per bit; values 0 and 1 are treated as 2.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- cfg_stop2  in  1  1 = two stop bits, 0 = one.
- tx  out  1  serial line, idle high.
- busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

## Operation
- Push on the rising edge where s_valid && s_ready.
- s_ready depends on full only. A pop in the same cycle does not allow a push into a full FIFO.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop, load the shifter, latch cfg_div/cfg_parity/cfg_stop2, drive tx=0, go to START.
  - START → DATA after div cycles.
  - DATA: shift out DATA_WIDTH bits, LSB first, div cycles each. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: even = XOR of data; odd = its inverse. Goes to STOP after div cycles.
  - STOP: tx=1 for div cycles, or 2×div if stop2. At the end, if the FIFO is non-empty, pop and go directly to START (tx=0 on the next cycle). Otherwise go to IDLE.
- Config changes mid-frame have no effect until the next frame start.
- Bit counter is $clog2(DATA_WIDTH+1) wide.
- Divisor counter is DIV_WIDTH wide and counts div-1 down to 0. A stop2 stop bit reloads the counter once.
- busy = (state != IDLE) || !empty.

## Timing
- Reset values (asynchronous assert; deassert synchronised externally): tx=1, s_ready=1, busy=0, fifo_level=0, state=IDLE, FIFO pointers 0.
- Reset asserted mid-frame: tx returns high immediately and queued data is discarded.
- Latency: a word pushed into an empty FIFO at edge k, with the FSM in IDLE, is popped at edge k+1. tx is low from edge k+1.
- fifo_level updates on the edge after push/pop. A simultaneous push and pop leaves it unchanged.
- Frame length = (1 + DATA_WIDTH + P + S) × div clocks, where P ∈ {0,1} and S ∈ {1,2}.
- Every bit is exactly div clocks with no jitter. There is zero gap between consecutive frames when queued.
- busy falls on the same edge the final stop bit ends with an empty FIFO.

## Structure
- Shared package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD);
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - constant MIN_DIV = 2.
- One sub-module: uart_sync_fifo (parameters WIDTH, DEPTH). Outputs full, empty and level. Has a first-word-valid read port with a pop strobe.
- The FSM and shifter stay in uart_tx_cfg.

## Test plan
- div=4, parity none, stop1, push 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. Frame is 40 clocks. busy is high for 40 clocks after the pop.
- div=3, even parity, push 0x07 → parity bit 1. Odd parity with the same data → parity bit 0. Frame is 33 clocks.
- stop2 with div=5 → stop level lasts 10 clocks. cfg_div=0 → each bit lasts 2 clocks.
- Push 5 words with FIFO_DEPTH=4 while the line is busy → s_ready drops when fifo_level reaches 4. All accepted words are sent back-to-back with no idle clocks. Output order matches push order.
- Change cfg_parity/cfg_div mid-frame → the current frame keeps the old settings and the next frame uses the new ones.
- Assert rstn low during DATA → tx=1, fifo_level=0 and busy=0 immediately. After release, tx stays idle until a new push.
